// File: rtl/mips_exec_core_if.sv
// Instruction issue and result bus of mips_exec_core.
// Handshake: an instruction transfers on a rising CLK edge where both
// instr_valid and instr_ready are high; the master holds INSTRUCTION stable
// while instr_valid is high. result_valid is a one-cycle pulse with no
// backpressure; ALUOut, Zero, Overflow, Illegal and wb_rd are meaningful
// during that pulse.
interface mips_exec_core_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       INSTRUCTION;
  logic              instr_valid;
  logic              instr_ready;
  logic              result_valid;
  logic [DATA_W-1:0] ALUOut;
  logic              Zero;
  logic              Overflow;
  logic              Illegal;
  logic [REG_AW-1:0] wb_rd;

  modport master (
    output INSTRUCTION, instr_valid,
    input  instr_ready, result_valid, ALUOut, Zero, Overflow, Illegal, wb_rd
  );

  modport slave (
    input  INSTRUCTION, instr_valid,
    output instr_ready, result_valid, ALUOut, Zero, Overflow, Illegal, wb_rd
  );
endinterface

// File: rtl/mips_exec_core.sv
// Multi-cycle MIPS R-type execution core: register file, four-state
// IDLE/DECODE/EXECUTE/WRITEBACK sequencer, ALU with status flags.
module mips_exec_core #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  mips_exec_core_if.slave    bus,
  input  logic               load_en,
  input  logic [REG_AW-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [1:0]         dbg_state
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int SHW      = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Fields of the latched instruction word
  logic [5:0]        op, funct, shamt6;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [SHW-1:0]    sh;
  logic              ready;
  logic              unused_bits;

  assign op          = instr_q[31:26];
  assign rs          = instr_q[21 +: REG_AW];
  assign rt          = instr_q[16 +: REG_AW];
  assign rd          = instr_q[11 +: REG_AW];
  assign shamt6      = {1'b0, instr_q[10:6]};
  assign sh          = shamt6[SHW-1:0];  // shift distance is shamt mod DATA_W
  assign funct       = instr_q[5:0];
  assign unused_bits = ^{instr_q, shamt6};

  // ALU: combinational result and flags from the latched operands
  logic [DATA_W-1:0] alu_res, sum, diff;
  logic              alu_ovf, alu_ill;
  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    if (op != 6'd0) begin
      alu_ill = 1'b1;
    end else begin
      case (funct)
        6'd32: begin
          alu_res = sum;
          alu_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
        end
        6'd33: alu_res = sum;
        6'd34: begin
          alu_res = diff;
          alu_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
        end
        6'd35: alu_res = diff;
        6'd36: alu_res = a_q & b_q;
        6'd37: alu_res = a_q | b_q;
        6'd38: alu_res = a_q ^ b_q;
        6'd39: alu_res = ~(a_q | b_q);
        6'd42: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        6'd43: alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
        6'd0:  alu_res = b_q << sh;
        6'd2:  alu_res = b_q >> sh;
        6'd3:  alu_res = $unsigned($signed(b_q) >>> sh);
        default: alu_ill = 1'b1;
      endcase
    end
  end

  // Loads are only taken in IDLE and then block issue for that cycle
  assign ready = (state_q == IDLE) && !load_en;

  // Sequencer next state, operand/result capture and register file writes
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    rd_d    = rd_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (load_en && (load_addr != '0)) regs_d[load_addr] = load_data;
        if (bus.instr_valid && ready) begin
          instr_d = bus.INSTRUCTION;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        state_d = EXECUTE;
      end
      EXECUTE: begin
        alu_d   = alu_res;
        zero_d  = (alu_res == '0);
        ovf_d   = alu_ovf;
        ill_d   = alu_ill;
        rd_d    = rd;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        // Overflowing or illegal results are shown but never committed
        if (!ill_q && !ovf_q && (rd_q != '0)) regs_d[rd_q] = alu_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset clearing everything
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      rd_q    <= rd_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.instr_ready  = ready;
  assign bus.result_valid = (state_q == WRITEBACK);
  assign bus.ALUOut       = alu_q;
  assign bus.Zero         = zero_q;
  assign bus.Overflow     = ovf_q;
  assign bus.Illegal      = ill_q;
  assign bus.wb_rd        = rd_q;
  assign dbg_data         = regs_q[dbg_addr];
  assign dbg_state        = state_q;
endmodule
